// File: rtl/demux_chan_sched.sv
// Channel sequencer for the 1-to-4 demux stage: takes a serial bit stream and hands
// BURST bits to each channel in the latched mask, lowest index first, via registered a/en/s.
module demux_chan_sched #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] ch_mask,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       a,
  output logic       en,
  output logic [1:0] s,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ch_q, ch_d;
  logic [1:0] s_q, s_d;
  logic       a_q, a_d;
  logic       en_q, en_d;
  logic       err_q, err_d;
  logic [2:0] lo_hit, nx_hit;

  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [2:0] first_set(input logic [3:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_comb begin
    lo_hit = first_set(ch_mask, 0);
    nx_hit = first_set(mask_q, int'(ch_q) + 1);
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    s_d       = s_q;
    a_d       = a_q;
    en_d      = 1'b0;
    err_d     = 1'b0;
    din_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (lo_hit[2]) begin
            mask_d  = ch_mask;
            ch_d    = lo_hit[1:0];
            cnt_d   = 4'd0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        busy      = 1'b1;
        din_ready = 1'b1;
        if (abort) begin
          // an accept coinciding with abort is dropped
          state_d = IDLE;
        end else if (din_valid) begin
          a_d  = din;
          en_d = 1'b1;
          s_d  = ch_q;
          if (cnt_q == LAST) begin
            cnt_d = 4'd0;
            if (nx_hit[2]) ch_d    = nx_hit[1:0];
            else           state_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 4'd0;
      cnt_q   <= 4'd0;
      ch_q    <= 2'd0;
      s_q     <= 2'd0;
      a_q     <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      s_q     <= s_d;
      a_q     <= a_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign a   = a_q;
  assign en  = en_q;
  assign s   = s_q;
  assign err = err_q;

endmodule

// File: tb/tb_demux_chan_sched.sv
// Directed bench for demux_chan_sched: one BURST=4 and one BURST=2 instance share stimulus.
module tb_demux_chan_sched;
  logic clk, rst, start, abort, din, din_valid;
  logic [3:0] ch_mask;

  logic r4, a4, en4, busy4, done4, err4;
  logic r2, a2, en2, busy2, done2, err2;
  logic [1:0] s4, s2;
  logic [7:0] obs4, obs2, exp_v;

  int pass_cnt = 0;
  int total_cnt = 0;

  demux_chan_sched #(.BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
    .din(din), .din_valid(din_valid), .din_ready(r4), .a(a4), .en(en4), .s(s4),
    .busy(busy4), .done(done4), .err(err4));

  demux_chan_sched #(.BURST(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
    .din(din), .din_valid(din_valid), .din_ready(r2), .a(a2), .en(en2), .s(s2),
    .busy(busy2), .done(done2), .err(err2));

  // observation word: {a, en, s[1:0], busy, done, err, din_ready}
  assign obs4 = {a4, en4, s4, busy4, done4, err4, r4};
  assign obs2 = {a2, en2, s2, busy2, done2, err2, r2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = 4'h0; din = 1'b0; din_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; ch_mask = 4'hF; din = 1'b1; din_valid = 1'b1;
    tick();
    total_cnt++;
    if (obs4 !== 8'h00) $display("FAIL reset4 got %b exp %b", obs4, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (obs2 !== 8'h00) $display("FAIL reset2 got %b exp %b", obs2, 8'h00);
    else pass_cnt++;
    rst = 1'b0; start = 1'b0; din_valid = 1'b0; din = 1'b0;
  endtask

  task automatic test_full_frame;
    logic [3:0] pat;
    pat = 4'b1101;  // pat[k%4] gives 1,0,1,1
    do_reset();
    start = 1'b1; ch_mask = 4'hF; din_valid = 1'b1; din = 1'b0;
    tick();
    start = 1'b0;
    total_cnt++;
    if (obs4 !== 8'b0000_1001) $display("FAIL full_start got %b exp %b", obs4, 8'b0000_1001);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      din = pat[k % 4];
      tick();
      exp_v = {pat[k % 4], 1'b1, 2'(k / 4), (k != 15), (k == 15), 1'b0, (k != 15)};
      total_cnt++;
      if (obs4 !== exp_v) $display("FAIL full_bit%0d got %b exp %b", k, obs4, exp_v);
      else pass_cnt++;
    end
    // start during the DONE cycle must not launch a frame
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_v = {1'b1, 1'b0, 2'd3, 4'b0000};
    total_cnt++;
    if (obs4 !== exp_v) $display("FAIL full_after_done got %b exp %b", obs4, exp_v);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs4 !== exp_v) $display("FAIL full_idle got %b exp %b", obs4, exp_v);
    else pass_cnt++;
    din_valid = 1'b0;
  endtask

  task automatic test_mask_skip;
    logic [3:0] d;
    logic [1:0] sexp [4];
    d = 4'b1001;
    sexp = '{2'd1, 2'd1, 2'd3, 2'd3};
    do_reset();
    start = 1'b1; ch_mask = 4'b1010; din_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = d[k];
      tick();
      exp_v = {d[k], 1'b1, sexp[k], (k != 3), (k == 3), 1'b0, (k != 3)};
      total_cnt++;
      if (obs2 !== exp_v) $display("FAIL skip_bit%0d got %b exp %b", k, obs2, exp_v);
      else pass_cnt++;
    end
    tick();
    exp_v = {d[3], 1'b0, 2'd3, 4'b0000};
    total_cnt++;
    if (obs2 !== exp_v) $display("FAIL skip_end got %b exp %b", obs2, exp_v);
    else pass_cnt++;
    din_valid = 1'b0;
  endtask

  task automatic test_valid_gaps;
    logic [7:0] d;
    logic v;
    int j;
    d = 8'b1011_0010;
    do_reset();
    start = 1'b1; ch_mask = 4'b0011; din_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      v = (k % 2 == 0);
      j = k / 2;
      din_valid = v;
      din = v ? d[j] : ~d[j];
      tick();
      exp_v = {d[j], v, 2'(j / 4), (k < 14), (k == 14), 1'b0, (k < 14)};
      total_cnt++;
      if (obs4 !== exp_v) $display("FAIL gap_cyc%0d got %b exp %b", k, obs4, exp_v);
      else pass_cnt++;
    end
    din_valid = 1'b0;
  endtask

  task automatic test_err;
    do_reset();
    start = 1'b1; ch_mask = 4'h0; din_valid = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (obs4 !== 8'b0000_0010) $display("FAIL err_pulse got %b exp %b", obs4, 8'b0000_0010);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs4 !== 8'h00) $display("FAIL err_clear got %b exp %b", obs4, 8'h00);
    else pass_cnt++;
    din_valid = 1'b0;
  endtask

  task automatic test_abort;
    logic seen;
    do_reset();
    start = 1'b1; ch_mask = 4'hF; din_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      din = 1'b1;
      tick();
      exp_v = {1'b1, 1'b1, 2'(k / 4), 4'b1001};
      total_cnt++;
      if (obs4 !== exp_v) $display("FAIL abort_pre%0d got %b exp %b", k, obs4, exp_v);
      else pass_cnt++;
    end
    abort = 1'b1; din = 1'b0;
    tick();
    abort = 1'b0;
    exp_v = {1'b1, 1'b0, 2'd1, 4'b0000};
    total_cnt++;
    if (obs4 !== exp_v) $display("FAIL abort_idle got %b exp %b", obs4, exp_v);
    else pass_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (en4 !== 1'b0 || done4 !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_quiet got %b exp %b", seen, 1'b0);
    else pass_cnt++;
    start = 1'b1; din = 1'b1;
    tick();
    start = 1'b0;
    tick();
    exp_v = {1'b1, 1'b1, 2'd0, 4'b1001};
    total_cnt++;
    if (obs4 !== exp_v) $display("FAIL abort_replay got %b exp %b", obs4, exp_v);
    else pass_cnt++;
    din_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    start = 1'b1; ch_mask = 4'hF; din_valid = 1'b1; din = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    exp_v = {1'b1, 1'b1, 2'd0, 4'b1001};
    total_cnt++;
    if (obs4 !== exp_v) $display("FAIL rstmid_pre got %b exp %b", obs4, exp_v);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (obs4 !== 8'h00) $display("FAIL rstmid_cleared got %b exp %b", obs4, 8'h00);
    else pass_cnt++;
    start = 1'b1; din = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      din = k[0];
      tick();
      exp_v = {k[0], 1'b1, 2'(k / 4), (k != 15), (k == 15), 1'b0, (k != 15)};
      total_cnt++;
      if (obs4 !== exp_v) $display("FAIL rstmid_bit%0d got %b exp %b", k, obs4, exp_v);
      else pass_cnt++;
    end
    din_valid = 1'b0;
    tick();
    exp_v = {1'b1, 1'b0, 2'd3, 4'b0000};
    total_cnt++;
    if (obs4 !== exp_v) $display("FAIL rstmid_end got %b exp %b", obs4, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = 4'h0; din = 1'b0; din_valid = 1'b0;
    test_reset();
    test_full_frame();
    test_mask_skip();
    test_valid_gaps();
    test_err();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/demux_chan_sched.md
Name: demux_chan_sched

Overview:
- Upstream sequencer for the 1-to-4 demultiplexer stage; produces that stage's `a`, `en` and `s` inputs.
- Accepts a serial bit stream with a valid/ready handshake.
- Delivers a frame: BURST consecutive bits to each channel enabled in a latched mask, lowest index first.
- Drives the demux with registered a/en/s. Signals busy while running and pulses done at frame end.

Parameters:
- BURST, 4, bits delivered to each enabled channel per frame; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  frame request; sampled only in IDLE.
- abort  input  1  cancels the frame in progress.
- ch_mask  input  4  channel enable mask; bit i enables channel i; latched on start.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block accepts din this cycle.
- a  output  1  data bit to the demux.
- en  output  1  demux enable; high exactly one cycle per accepted bit.
- s  output  2  demux select (channel index).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a frame completes.
- err  output  1  one-cycle pulse when start is given with ch_mask==0.

Behaviour:
- Reset values, applied at the first clk edge with rst=1:
  - state=IDLE; a=0, en=0, s=2'b00.
  - busy=0, done=0, err=0.
  - latched mask=0, bit counter=0.
- rst overrides every other input, including mid-frame. A partially delivered frame is discarded and done does not pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - din_ready=0.
  - start=1 and ch_mask!=0: latch mask, set current channel to the lowest set bit, clear bit counter, go to RUN.
  - start=1 and ch_mask==0: err=1 for the next cycle, stay in IDLE.
  - din_valid is ignored.
- RUN:
  - busy=1 and din_ready=1 (combinational from state).
  - Accept = din_valid & din_ready.
  - On accept, the next cycle shows: a=din, en=1, s=current channel. Latency is exactly 1 clock from accept to en.
  - Cycles without an accept: en=0, while a and s hold their last values.
  - Each accept increments the bit counter. When the counter reaches BURST-1 on an accept:
    - counter goes to 0;
    - current channel advances to the next higher set bit of the latched mask;
    - if no higher set bit exists, the frame is complete and the state goes to DONE.
  - Channel advance never wraps within a frame; masked channels are skipped with no idle cycle.
  - start and ch_mask changes in RUN are ignored.
- DONE:
  - Lasts one cycle. done=1, din_ready=0, busy=0, then IDLE.
  - en in this cycle reflects the final accepted bit, so the final en and done coincide.
- abort in RUN:
  - State goes to IDLE at the next edge and en=0 from then on.
  - An accept in the same cycle as abort is discarded, so en stays 0.
  - done is not pulsed.
  - abort in IDLE or DONE has no effect.
- start asserted in the DONE cycle is ignored; a new frame requires start in IDLE.
- Total accepts per frame = BURST × popcount(mask).

Test Plan:
- Reset, then BURST=4, mask=4'b1111, din_valid held 1, din pattern 1,0,1,1 repeating:
  - en=1 for 16 consecutive cycles starting 2 cycles after start;
  - s = 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3;
  - a follows din delayed 1 cycle;
  - done pulses with the 16th en; busy falls at the same time.
- mask=4'b1010, BURST=2, din_valid=1 → s sequence 1,1,3,3; channels 0 and 2 never selected; done after 4 bits.
- din_valid toggled 1,0,1,0 during RUN → en follows valid delayed 1 cycle; s and a hold during the gaps; counter advances only on accepts.
- start with mask=4'b0000 → err pulses 1 cycle; busy stays 0; din_ready stays 0.
- abort after 5 accepts (mask=4'b1111, BURST=4) → IDLE next cycle; no further en; done never pulses. A following start replays from channel 0.
- rst=1 asserted mid-frame (after 3 accepts) → at the next edge all outputs are at reset values and state is IDLE; a subsequent frame completes normally.
